// File: rtl/mux81_sched_pkg.sv
// mux81_sched_pkg: shared state encoding and width constants for the round-robin mux scheduler.
package mux81_sched_pkg;
  localparam int NCH = 8;
  localparam int SW = 3;
  localparam int CW = 4;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/mux81_sched_if.sv
// mux81_sched_if: requester/consumer bundle; lock exists only with MUX81_SCHED_LOCK_EN.
interface mux81_sched_if;
  import mux81_sched_pkg::*;
  logic [NCH-1:0] req;
  logic [NCH-1:0] i;
  logic out_ready;
  logic [SW-1:0] s;
  logic [NCH-1:0] gnt;
  logic y;
  logic y_valid;
  logic last;
`ifdef MUX81_SCHED_LOCK_EN
  logic lock;
  modport master(output req, i, out_ready, lock, input s, gnt, y, y_valid, last);
  modport slave(input req, i, out_ready, lock, output s, gnt, y, y_valid, last);
`else
  modport master(output req, i, out_ready, input s, gnt, y, y_valid, last);
  modport slave(input req, i, out_ready, output s, gnt, y, y_valid, last);
`endif
endinterface

// File: rtl/mux81_sched_rr_pick8.sv
// rr_pick8: first set request scanning upward from ptr with wrap, as one-hot and index.
module rr_pick8
  import mux81_sched_pkg::*;
(
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  ptr_i,
  output logic [NCH-1:0] win_o,
  output logic [SW-1:0]  idx_o
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0] rot;
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[NCH-1:0];
  // descending scan so the smallest offset from ptr is the last one written
  always_comb begin
    idx_o = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (rot[k]) idx_o = ptr_i + SW'(k);
    win_o = (|req_i) ? (NCH'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/mux_81.sv
// mux_81: single-bit 8:1 multiplexer datapath.
module mux_81 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

// File: rtl/mux81_sched.sv
// mux81_sched: round-robin burst scheduler sharing mux_81 among eight requesters.
// Define MUX81_SCHED_LOCK_EN to add the lock input that extends a grant past BURST_LEN.
module mux81_sched
  import mux81_sched_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  mux81_sched_if.slave bus
);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  state_t state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d, win;
  logic [SW-1:0] s_q, s_d, ptr_q, ptr_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy, mux_y, lk, xfer, rel;
`ifdef MUX81_SCHED_LOCK_EN
  assign lk = bus.lock;
`else
  assign lk = 1'b0;
`endif
  rr_pick8 u_pick (.req_i(bus.req), .ptr_i(ptr_q), .win_o(win), .idx_o(idx));
  mux_81 u_mux (.i(bus.i), .s(s_q), .y(mux_y));
  assign busy = state_q == BUSY;
  assign bus.y = busy & mux_y;
  assign bus.y_valid = busy & bus.req[s_q];
  assign bus.last = bus.y_valid & (cnt_q == LAST_CNT) & ~lk;
  assign bus.gnt = gnt_q;
  assign bus.s = s_q;
  assign xfer = bus.y_valid & bus.out_ready;
  // owner withdrawal wins over a simultaneous final beat: no transfer is counted
  assign rel = busy & (~bus.req[s_q] | (xfer & bus.last));
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    s_d = s_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (!busy && |bus.req) begin
      state_d = BUSY;
      gnt_d = win;
      s_d = idx;
      cnt_d = '0;
    end else if (rel) begin
      state_d = IDLE;
      gnt_d = '0;
      ptr_d = s_q + 1'b1;
      cnt_d = '0;
    end else if (xfer && cnt_q != LAST_CNT) cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      s_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      s_q <= s_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux81_sched.sv
// tb_mux81_sched: directed table, hand sequences and randomized model check of mux81_sched.
module tb_mux81_sched;
  localparam int BL = 4;
  typedef struct {
    logic [7:0] r, d;
    logic rd;
    logic [7:0] g;
    logic [2:0] s;
    logic y, yv, l;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[10];
  mux81_sched_if bus();
  mux81_sched #(.BURST_LEN(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(logic [7:0] g, logic [2:0] s, logic y, logic yv, logic l);
    return {2'b00, g, s, y, yv, l};
  endfunction
  function automatic logic [15:0] obs();
    return pk(bus.gnt, bus.s, bus.y, bus.y_valid, bus.last);
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [7:0] r, input logic [7:0] d, input logic rd);
    bus.req = r;
    bus.i = d;
    bus.out_ready = rd;
    @(negedge clk);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r, d;
    logic rd, lk, yv, l;
    int owner, ptr, sel, beats;
    bus.req = 8'hFF;
    bus.i = 8'hAA;
    bus.out_ready = 1'b1;
`ifdef MUX81_SCHED_LOCK_EN
    bus.lock = 1'b0;
`endif
    tbl[0] = '{8'h81, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h81, 8'h00, 1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h81, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h81, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h01, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h81, 8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{8'h81, 8'h00, 1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 1'b0};
    // reset with all requests high, then full round-robin rotation 0..7,0
    drive(8'hFF, 8'hAA, 1'b1);
    chk("reset_state", obs(), pk(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 9; n++) begin
      drive(8'hFF, 8'h55, 1'b1);
      chk("rr_idle", 16'({bus.gnt, bus.y_valid}), 16'h0000);
      tick();
      for (int b = 0; b < BL; b++) begin
        drive(8'hFF, 8'h55, 1'b1);
        chk("rr_beat", 16'({bus.gnt, bus.s, bus.y_valid, bus.last}),
            16'({8'(1 << (n % 8)), 3'(n % 8), 1'b1, b == BL - 1}));
        tick();
      end
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].r, tbl[k].d, tbl[k].rd);
      chk($sformatf("table_%0d", k), obs(), pk(tbl[k].g, tbl[k].s, tbl[k].y, tbl[k].yv, tbl[k].l));
      tick();
    end
    // stall on ch3: nothing advances while out_ready is low
    do_reset();
    drive(8'h08, 8'h08, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(8'h08, 8'h08, 1'b0);
      chk("stall_hold", obs(), pk(8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
      tick();
    end
    for (int b = 0; b < BL; b++) begin
      drive(8'h08, 8'h08, 1'b1);
      chk("stall_resume", obs(), pk(8'h08, 3'd3, 1'b1, 1'b1, b == BL - 1));
      tick();
    end
    drive(8'h08, 8'h08, 1'b1);
    chk("stall_bubble", obs(), pk(8'h00, 3'd3, 1'b0, 1'b0, 1'b0));
    tick();
    // asynchronous reset in the middle of a ch5 burst
    do_reset();
    drive(8'h20, 8'hFF, 1'b1);
    tick();
    drive(8'h20, 8'hFF, 1'b1);
    chk("pre_reset_ch5", obs(), pk(8'h20, 3'd5, 1'b1, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), pk(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1);
    tick();
    drive(8'hFF, 8'hFF, 1'b1);
    chk("after_reset_ch0", obs(), pk(8'h01, 3'd0, 1'b1, 1'b1, 1'b0));
    tick();
`ifdef MUX81_SCHED_LOCK_EN
    do_reset();
    bus.lock = 1'b1;
    drive(8'h02, 8'h02, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(8'h02, 8'h02, 1'b1);
      chk("lock_hold", obs(), pk(8'h02, 3'd1, 1'b1, 1'b1, 1'b0));
      tick();
    end
    bus.lock = 1'b0;
    drive(8'h02, 8'h02, 1'b1);
    chk("lock_last", obs(), pk(8'h02, 3'd1, 1'b1, 1'b1, 1'b1));
    tick();
    drive(8'h02, 8'h02, 1'b1);
    chk("lock_release", obs(), pk(8'h00, 3'd1, 1'b0, 1'b0, 1'b0));
    tick();
`endif
    // randomized traffic against a transaction-level model
    do_reset();
    owner = -1;
    ptr = 0;
    sel = 0;
    beats = 0;
    r = 8'hFF;
    lk = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) r = r ^ 8'(1 << $urandom_range(7));
      d = 8'($urandom);
      rd = $urandom_range(3) != 0;
`ifdef MUX81_SCHED_LOCK_EN
      lk = $urandom_range(15) < 3;
      bus.lock = lk;
`endif
      drive(r, d, rd);
      yv = owner >= 0 && r[owner];
      l = yv && beats == BL - 1 && !lk;
      chk("random", obs(), pk(owner >= 0 ? 8'(1 << owner) : 8'h00, 3'(sel),
          owner >= 0 && d[owner], yv, l));
      if (owner < 0) begin
        for (int k = 0; k < 8; k++)
          if (owner < 0 && r[(ptr + k) % 8]) owner = (ptr + k) % 8;
        if (owner >= 0) begin
          sel = owner;
          beats = 0;
        end
      end else if (!r[owner] || (yv && rd && l)) begin
        ptr = (owner + 1) % 8;
        owner = -1;
      end else if (yv && rd && beats < BL - 1) beats++;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
